// File: rtl/blram_arbiter.sv
// blram_arbiter: shares one single-port block RAM between the CPU port (ch0)
// and a host/debug loader (ch1); round-robin with a bounded atomic lock.
module blram_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 10,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lock_active,
    output logic              lock_owner
);

    localparam int CNT_W = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    localparam logic ST_UNLOCKED = 1'b0;
    localparam logic ST_LOCKED   = 1'b1;

    logic             state_q;
    logic             owner_q;
    logic             ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       blk_q;
    logic             rv0_q;
    logic             rv1_q;

    logic       elig0;
    logic       elig1;
    logic       owner_lock;
    logic       sel_lock;
    logic       sel_blk;
    logic       release_req;
    logic       timeout;
    logic       acquire;
    logic [1:0] blk_nxt;

    // While locked only the owner may be granted, even if it is idle.
    always_comb begin
        elig0 = ~rst & req0 &
                ((state_q == ST_UNLOCKED) | (owner_q == 1'b0));
        elig1 = ~rst & req1 &
                ((state_q == ST_UNLOCKED) | (owner_q == 1'b1));
        gnt0  = elig0 & (~elig1 | ptr_q);
        gnt1  = elig1 & (~elig0 | ~ptr_q);
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            gnt0: begin
                mem_we    = we0;
                mem_addr  = addr0;
                mem_wdata = wdata0;
            end
            gnt1: begin
                mem_we    = we1;
                mem_addr  = addr1;
                mem_wdata = wdata1;
            end
            default: ;
        endcase
    end

    always_comb begin
        owner_lock  = owner_q ? lock1 : lock0;
        sel_lock    = gnt1 ? lock1 : lock0;
        sel_blk     = gnt1 ? blk_q[1] : blk_q[0];
        release_req = (state_q == ST_LOCKED) & ~owner_lock;
        timeout     = (state_q == ST_LOCKED) & owner_lock &
                      (LOCK_MAX != 0) & (cnt_q == CNT_LIM);
        acquire     = (state_q == ST_UNLOCKED) & (gnt0 | gnt1) &
                      sel_lock & ~sel_blk;
        // A timed-out owner stays barred until it drops its lock line.
        blk_nxt[0]  = (timeout & ~owner_q) | (blk_q[0] & lock0);
        blk_nxt[1]  = (timeout & owner_q) | (blk_q[1] & lock1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_UNLOCKED;
            owner_q <= 1'b0;
            ptr_q   <= 1'b1;
            cnt_q   <= '0;
            blk_q   <= '0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            rv0_q <= gnt0 & ~we0;
            rv1_q <= gnt1 & ~we1;
            blk_q <= blk_nxt;
            if (timeout) begin
                ptr_q <= owner_q;
            end else if (gnt0 | gnt1) begin
                ptr_q <= gnt1;
            end
            case (state_q)
                ST_UNLOCKED: begin
                    if (acquire) begin
                        state_q <= ST_LOCKED;
                        owner_q <= gnt1;
                        cnt_q   <= CNT_ONE;
                    end
                end
                ST_LOCKED: begin
                    if (release_req | timeout) begin
                        state_q <= ST_UNLOCKED;
                        cnt_q   <= '0;
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= ST_UNLOCKED;
            endcase
        end
    end

    // Read data is a straight pass-through; rvalidN says whose it is.
    assign rdata       = mem_rdata;
    assign rvalid0     = rv0_q & ~rst;
    assign rvalid1     = rv1_q & ~rst;
    assign lock_active = state_q;
    assign lock_owner  = owner_q;

endmodule

// File: tb/tb_blram_arbiter.sv
// tb_blram_arbiter: randomized and directed stimulus against a
// transaction-level arbiter/RAM model with a read-response scoreboard.
module tb_blram_arbiter;

    localparam int LM = 4;

    typedef struct {
        int         due;
        bit         ch;
        logic [9:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, lock0, req1, we1, lock1;
    logic [5:0] addr0, addr1;
    logic [9:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [9:0] rdata;
    logic       mem_we;
    logic [5:0] mem_addr;
    logic [9:0] mem_wdata;
    logic [9:0] mem_rdata;
    logic       lock_active, lock_owner;

    logic [9:0] ram [64];
    logic [9:0] ref_mem [64];
    exp_t       sbq [$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bit       m_locked = 1'b0;
    bit       m_owner  = 1'b0;
    int       m_held   = 0;
    bit       m_last   = 1'b1;
    bit [1:0] m_nolock = 2'b00;

    blram_arbiter #(
        .ADDR_W  (6),
        .DATA_W  (10),
        .LOCK_MAX(LM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .we0        (we0),
        .lock0      (lock0),
        .addr0      (addr0),
        .wdata0     (wdata0),
        .gnt0       (gnt0),
        .rvalid0    (rvalid0),
        .req1       (req1),
        .we1        (we1),
        .lock1      (lock1),
        .addr1      (addr1),
        .wdata1     (wdata1),
        .gnt1       (gnt1),
        .rvalid1    (rvalid1),
        .rdata      (rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .lock_active(lock_active),
        .lock_owner (lock_owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] init_val(input int i);
        if (i == 50) return 10'd5;
        if (i == 51) return 10'd10;
        return 10'(i * 37 + 11);
    endfunction

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Registered-read RAM; read-during-write returns the old word.
    initial begin
        for (int i = 0; i < 64; i++) ram[i] = init_val(i);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // Reference model: who should win this cycle, what the RAM sees,
    // and what lock state follows.
    initial begin : model
        bit         e0, e1, any, win, wr;
        bit [1:0]   lk;
        logic [5:0] a;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                e0  = !rst && req0 && !(m_locked && m_owner);
                e1  = !rst && req1 && !(m_locked && !m_owner);
                any = e0 || e1;
                win = (e0 && e1) ? !m_last : e1;
                wr  = win ? we1 : we0;
                a   = win ? addr1 : addr0;
                check("gnt0", gnt0, any && !win);
                check("gnt1", gnt1, any && win);
                check("mem_we", mem_we, any && wr);
                check("mem_addr", mem_addr, any ? a : 6'd0);
                check("mem_wdata", mem_wdata,
                      any ? (win ? wdata1 : wdata0) : 10'd0);
                check("lock_active", lock_active, m_locked);
                if (m_locked) check("lock_owner", lock_owner, m_owner);
                lk = {lock1, lock0};
                if (rst) begin
                    m_locked = 1'b0;
                    m_owner  = 1'b0;
                    m_held   = 0;
                    m_last   = 1'b1;
                    m_nolock = 2'b00;
                end else begin
                    if (any) begin
                        m_last = win;
                        if (wr) ref_mem[a] = win ? wdata1 : wdata0;
                        else sbq.push_back('{cyc + 1, win, ref_mem[a]});
                    end
                    if (m_locked) begin
                        if (!lk[m_owner]) begin
                            m_locked = 1'b0;
                        end else if (m_held >= LM) begin
                            m_locked          = 1'b0;
                            m_last            = m_owner;
                            m_nolock[m_owner] = 1'b1;
                        end else begin
                            m_held++;
                        end
                    end else if (any && lk[win] && !m_nolock[win]) begin
                        m_locked = 1'b1;
                        m_owner  = win;
                        m_held   = 1;
                    end
                    for (int c = 0; c < 2; c++)
                        if (!lk[c]) m_nolock[c] = 1'b0;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a read returns.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rvalid_in_reset", {rvalid1, rvalid0}, 0);
                sbq.delete();
            end else if (rvalid0 || rvalid1) begin
                if (sbq.size() == 0) begin
                    check("rvalid_unexpected", {rvalid1, rvalid0}, 0);
                end else begin
                    e = sbq.pop_front();
                    check("rvalid_cycle", cyc, e.due);
                    check("rvalid_chan", {rvalid1, rvalid0},
                          e.ch ? 2 : 1);
                    check("rdata", rdata, e.data);
                end
            end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                check("rvalid_missing", {rvalid1, rvalid0},
                      e.ch ? 2 : 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic r, w, l,
                        input logic [5:0] a, input logic [9:0] d);
        req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
    endtask

    task automatic set1(input logic r, w, l,
                        input logic [5:0] a, input logic [9:0] d);
        req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
    endtask

    initial begin : stim
        int c0, c1;
        bit seen0, seen1;
        rst = 1'b1;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_lock_owner", lock_owner, 0);
        tick();

        // Simultaneous reads of 50/51 after reset: ch0 first.
        set0(1, 0, 0, 6'd50, 0);
        set1(1, 0, 0, 6'd51, 0);
        @(negedge clk);
        check("first_contention", {gnt1, gnt0}, 2'b01);
        tick();
        set0(0, 0, 0, 0, 0);
        tick();
        set1(0, 0, 0, 0, 0);
        tick();

        // ch1 writes 0x2A to 52, then ch0 reads it back.
        set1(1, 1, 0, 6'd52, 10'h2A);
        tick();
        set1(0, 0, 0, 0, 0);
        set0(1, 0, 0, 6'd52, 0);
        tick();
        set0(0, 0, 0, 0, 0);
        repeat (2) tick();

        // Continuous contention for 8 cycles.
        c0 = 0;
        c1 = 0;
        set0(1, 0, 0, 6'd1, 0);
        set1(1, 0, 0, 6'd2, 0);
        repeat (8) begin
            @(negedge clk);
            c0 += int'(gnt0);
            c1 += int'(gnt1);
            tick();
        end
        check("alt_gnt0_count", c0, 4);
        check("alt_gnt1_count", c1, 4);
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        tick();

        // ch1 locked 3-access sequence against a busy ch0.
        set1(1, 0, 1, 6'd20, 0);
        tick();
        set0(1, 0, 0, 6'd10, 0);
        tick();
        set1(1, 0, 1, 6'd21, 0);
        @(negedge clk);
        check("lock_stall_gnt0", gnt0, 0);
        tick();
        set1(1, 0, 0, 6'd22, 0);
        tick();
        set1(0, 0, 0, 0, 0);
        @(negedge clk);
        check("after_release_gnt0", gnt0, 1);
        tick();
        set0(0, 0, 0, 0, 0);
        tick();

        // ch1 holds lock1 forever: timeout, then no relock.
        set1(1, 0, 1, 6'd30, 0);
        set0(1, 0, 0, 6'd31, 0);
        repeat (12) tick();
        set1(0, 0, 0, 0, 0);
        tick();
        set1(1, 0, 1, 6'd33, 0);
        repeat (4) tick();
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        repeat (2) tick();

        // Reset right after a ch0 read grant.
        set0(1, 0, 0, 6'd40, 0);
        tick();
        rst = 1'b1;
        set0(0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_drops_rvalid0", rvalid0, 0);
        tick();
        rst = 1'b0;
        set0(1, 0, 0, 6'd41, 0);
        set1(1, 0, 0, 6'd42, 0);
        @(negedge clk);
        check("post_rst_contention", {gnt1, gnt0}, 2'b01);
        tick();
        set0(0, 0, 0, 0, 0);
        tick();
        set1(0, 0, 0, 0, 0);
        tick();

        // Randomized traffic; pending requests are held until granted.
        repeat (1500) begin
            @(negedge clk);
            seen0 = gnt0;
            seen1 = gnt1;
            tick();
            rst = ($urandom_range(0, 199) == 0);
            if (!(req0 && !seen0)) begin
                req0   = ($urandom_range(0, 9) < 7);
                we0    = ($urandom_range(0, 9) < 3);
                addr0  = 6'($urandom);
                wdata0 = 10'($urandom);
                if ($urandom_range(0, 9) < 2) lock0 = !lock0;
            end
            if (!(req1 && !seen1)) begin
                req1   = ($urandom_range(0, 9) < 7);
                we1    = ($urandom_range(0, 9) < 3);
                addr1  = 6'($urandom);
                wdata1 = 10'($urandom);
                if ($urandom_range(0, 9) < 2) lock1 = !lock1;
            end
        end

        rst = 1'b0;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        repeat (4) tick();
        check("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
